// File: rtl/world_if_gen.sv
// world_if_gen: PicoBlaze I/O register block for the Rojobot world emulator.
// Holding registers, masked atomic snapshot into SysRegs, map ports and an update handshake.
module world_if_gen #(
    parameter int DW       = 8,
    parameter int NCH      = 6,
    parameter int MAPVAL_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Wr_Strobe,
    input  logic                Rd_Strobe,
    input  logic [7:0]          AddrIn,
    input  logic [DW-1:0]       DataIn,
    output logic [DW-1:0]       DataOut,
    input  logic [DW-1:0]       MotCtl,
    output logic [NCH*DW-1:0]   SysRegs,
    output logic [DW-1:0]       MapX,
    output logic [DW-1:0]       MapY,
    input  logic [MAPVAL_W-1:0] MapVal,
    input  logic [DW-1:0]       BotConfig,
    output logic                upd_sysregs,
    input  logic                upd_ack,
    output logic [DW-1:0]       snap_seq
);

    localparam logic [4:0] A_MOT    = 5'h00;
    localparam logic [4:0] A_MAPX   = 5'h08;
    localparam logic [4:0] A_MAPY   = 5'h09;
    localparam logic [4:0] A_MAPVAL = 5'h0A;
    localparam logic [4:0] A_BOT    = 5'h0B;
    localparam logic [4:0] A_LOAD   = 5'h0C;
    localparam logic [4:0] A_OVR    = 5'h0D;
    localparam logic [4:0] A_UPD    = 5'h0E;
    localparam logic [4:0] A_STATUS = 5'h0F;
    localparam logic [4:0] A_SEQ    = 5'h10;

    localparam logic [DW-1:0] CNT_MAX = {DW{1'b1}};
    localparam logic [DW-1:0] CNT_ONE = DW'(1);

    logic [4:0]        addr;
    logic [DW-1:0]     hold_q [NCH];
    logic [NCH*DW-1:0] sys_q;
    logic [DW-1:0]     map_x_q;
    logic [DW-1:0]     map_y_q;
    logic              upd_q;
    logic [DW-1:0]     seq_q;
    logic [DW-1:0]     ovr_q;
    logic [DW-1:0]     dout_q;
    logic [DW-1:0]     rd_data;
    logic              wr_load;
    logic              wr_ovr;
    logic              wr_upd;
    logic              load_any;
    logic              unused_ok;

    // Reads have no side effects, so the read strobe and upper address bits are not needed.
    assign unused_ok = ^{Rd_Strobe, AddrIn[7:5]};

    assign addr     = AddrIn[4:0];
    assign wr_load  = Wr_Strobe && (addr == A_LOAD);
    assign wr_ovr   = Wr_Strobe && (addr == A_OVR);
    assign wr_upd   = Wr_Strobe && (addr == A_UPD);
    assign load_any = |DataIn[NCH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
        end else if (Wr_Strobe) begin
            for (int i = 0; i < NCH; i++) begin
                if (addr == 5'(i + 1)) hold_q[i] <= DataIn;
            end
        end
    end

    // All selected channels copy from the holding registers on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sys_q <= '0;
            seq_q <= '0;
        end else if (wr_load) begin
            for (int i = 0; i < NCH; i++) begin
                if (DataIn[i]) sys_q[i*DW +: DW] <= hold_q[i];
            end
            if (load_any) seq_q <= seq_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_x_q <= '0;
            map_y_q <= '0;
        end else if (Wr_Strobe) begin
            if (addr == A_MAPX) map_x_q <= DataIn;
            if (addr == A_MAPY) map_y_q <= DataIn;
        end
    end

    // Handshake: upd_sysregs is a sticky level set by an UPD write and cleared by
    // upd_ack; an UPD write while it is still set and unacknowledged is an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_q <= 1'b0;
            ovr_q <= '0;
        end else begin
            if (wr_upd) begin
                upd_q <= 1'b1;
                if (upd_q && !upd_ack && (ovr_q != CNT_MAX)) ovr_q <= ovr_q + CNT_ONE;
            end else if (upd_ack) begin
                upd_q <= 1'b0;
            end
            if (wr_ovr) ovr_q <= '0;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (addr == 5'(i + 1)) rd_data = hold_q[i];
        end
        case (addr)
            A_MOT:    rd_data = MotCtl;
            A_MAPX:   rd_data = map_x_q;
            A_MAPY:   rd_data = map_y_q;
            A_MAPVAL: rd_data = DW'(MapVal);
            A_BOT:    rd_data = BotConfig;
            A_OVR:    rd_data = ovr_q;
            A_STATUS: rd_data = DW'(upd_q);
            A_SEQ:    rd_data = seq_q;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dout_q <= '0;
        else       dout_q <= rd_data;
    end

    assign DataOut     = dout_q;
    assign SysRegs     = sys_q;
    assign MapX        = map_x_q;
    assign MapY        = map_y_q;
    assign upd_sysregs = upd_q;
    assign snap_seq    = seq_q;

endmodule

// File: tb/tb_world_if_gen.sv
// Self-checking bench for world_if_gen: directed vector table, multi-cycle corner
// sequences and random traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_world_if_gen;
    localparam int DW  = 8;
    localparam int NCH = 6;
    localparam int MW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              Wr_Strobe, Rd_Strobe;
    logic [7:0]        AddrIn;
    logic [DW-1:0]     DataIn, DataOut, MotCtl, MapX, MapY, BotConfig, snap_seq;
    logic [NCH*DW-1:0] SysRegs;
    logic [MW-1:0]     MapVal;
    logic              upd_sysregs, upd_ack;

    always #5 clk = ~clk;

    world_if_gen #(.DW(DW), .NCH(NCH), .MAPVAL_W(MW)) dut (
        .clk(clk), .reset(reset), .Wr_Strobe(Wr_Strobe), .Rd_Strobe(Rd_Strobe),
        .AddrIn(AddrIn), .DataIn(DataIn), .DataOut(DataOut), .MotCtl(MotCtl),
        .SysRegs(SysRegs), .MapX(MapX), .MapY(MapY), .MapVal(MapVal),
        .BotConfig(BotConfig), .upd_sysregs(upd_sysregs), .upd_ack(upd_ack),
        .snap_seq(snap_seq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, plain integers
    int m_hold[NCH];
    int m_sys[NCH];
    int m_mapx, m_mapy, m_upd, m_seq, m_ovr, m_dout;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic       ack;
        logic [7:0] exp_dout;
        logic       exp_upd;
        logic [7:0] exp_seq;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_hold[i] = 0;
            m_sys[i]  = 0;
        end
        m_mapx = 0; m_mapy = 0; m_upd = 0; m_seq = 0; m_ovr = 0; m_dout = 0;
    endtask

    function automatic int model_read(input int a);
        if (a >= 1 && a <= NCH) return m_hold[a-1];
        case (a)
            0:  return int'(MotCtl);
            8:  return m_mapx;
            9:  return m_mapy;
            10: return int'(MapVal);
            11: return int'(BotConfig);
            13: return m_ovr;
            15: return m_upd;
            16: return m_seq;
            default: return 0;
        endcase
    endfunction

    // Advances the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        int a = int'(AddrIn[4:0]);
        m_dout = model_read(a);
        if (Wr_Strobe) begin
            if (a >= 1 && a <= NCH) m_hold[a-1] = int'(DataIn);
            else if (a == 8) m_mapx = int'(DataIn);
            else if (a == 9) m_mapy = int'(DataIn);
            else if (a == 12) begin
                if ((int'(DataIn) % (1 << NCH)) != 0) m_seq = (m_seq + 1) % 256;
                for (int i = 0; i < NCH; i++) begin
                    if (DataIn[i]) m_sys[i] = m_hold[i];
                end
            end else if (a == 13) m_ovr = 0;
        end
        if (Wr_Strobe && a == 14) begin
            if (m_upd == 1 && !upd_ack) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
            m_upd = 1;
        end else if (upd_ack) begin
            m_upd = 0;
        end
    endtask

    task automatic cycle(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                         input logic ack);
        Wr_Strobe = wr;
        Rd_Strobe = !wr;
        AddrIn    = addr;
        DataIn    = data;
        upd_ack   = ack;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [NCH*DW-1:0] es;
        es = '0;
        for (int i = 0; i < NCH; i++) es[i*DW +: DW] = DW'(m_sys[i]);
        chk({tag, "_dout"}, DataOut, m_dout);
        chk({tag, "_sys"}, SysRegs, es);
        chk({tag, "_mapx"}, MapX, m_mapx);
        chk({tag, "_mapy"}, MapY, m_mapy);
        chk({tag, "_upd"}, upd_sysregs, m_upd);
        chk({tag, "_seq"}, snap_seq, m_seq);
    endtask

    task automatic add(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                       input logic ack, input logic [7:0] ed, input logic eu,
                       input logic [7:0] es);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.ack = ack;
        v.exp_dout = ed; v.exp_upd = eu; v.exp_seq = es;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        Wr_Strobe = 1'b0; Rd_Strobe = 1'b0; AddrIn = '0; DataIn = '0; upd_ack = 1'b0;
        MotCtl = 8'h3C; BotConfig = 8'hA5; MapVal = 2'b10;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model("reset");
        reset = 1'b0;

        // Directed table: write, addr, data, ack, DataOut, upd_sysregs, snap_seq after the edge
        for (int i = 1; i <= 6; i++) add(1, 8'(i), 8'(8'h10 + i), 0, 8'h00, 0, 8'h00);
        add(1, 8'h0C, 8'h05, 0, 8'h00, 0, 8'h01);
        add(0, 8'h03, 8'h00, 0, 8'h13, 0, 8'h01);
        add(0, 8'h10, 8'h00, 0, 8'h01, 0, 8'h01);
        add(0, 8'h0A, 8'h00, 0, 8'h02, 0, 8'h01);
        add(0, 8'h00, 8'h00, 0, 8'h3C, 0, 8'h01);
        add(0, 8'h0B, 8'h00, 0, 8'hA5, 0, 8'h01);
        add(1, 8'h0A, 8'hFF, 0, 8'h02, 0, 8'h01);
        add(1, 8'h0B, 8'hFF, 0, 8'hA5, 0, 8'h01);
        add(1, 8'h00, 8'hFF, 0, 8'h3C, 0, 8'h01);
        add(0, 8'h07, 8'h00, 0, 8'h00, 0, 8'h01);
        add(1, 8'h07, 8'hEE, 0, 8'h00, 0, 8'h01);
        add(0, 8'h07, 8'h00, 0, 8'h00, 0, 8'h01);
        add(1, 8'h0C, 8'h00, 0, 8'h00, 0, 8'h01);
        add(1, 8'h0E, 8'h00, 0, 8'h00, 1, 8'h01);
        add(1, 8'h0E, 8'h00, 0, 8'h00, 1, 8'h01);
        add(0, 8'h0D, 8'h00, 0, 8'h01, 1, 8'h01);
        add(1, 8'h0E, 8'h00, 1, 8'h00, 1, 8'h01);
        add(0, 8'h0D, 8'h00, 0, 8'h01, 1, 8'h01);
        add(0, 8'h0F, 8'h00, 1, 8'h01, 0, 8'h01);
        add(0, 8'h0F, 8'h00, 0, 8'h00, 0, 8'h01);
        add(1, 8'h0D, 8'h00, 0, 8'h01, 0, 8'h01);
        add(0, 8'h0D, 8'h00, 0, 8'h00, 0, 8'h01);
        add(1, 8'h08, 8'h5A, 0, 8'h00, 0, 8'h01);
        add(0, 8'h08, 8'h00, 0, 8'h5A, 0, 8'h01);
        add(1, 8'h10, 8'h33, 0, 8'h01, 0, 8'h01);
        add(0, 8'h10, 8'h00, 0, 8'h01, 0, 8'h01);
        add(1, 8'h0C, 8'hC0, 0, 8'h00, 0, 8'h01);
        add(0, 8'h10, 8'h00, 0, 8'h01, 0, 8'h01);

        foreach (tbl[i]) begin
            cycle(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].ack);
            chk($sformatf("tbl%0d_dout", i), DataOut, tbl[i].exp_dout);
            chk($sformatf("tbl%0d_upd", i), upd_sysregs, tbl[i].exp_upd);
            chk($sformatf("tbl%0d_seq", i), snap_seq, tbl[i].exp_seq);
            check_model("tblm");
        end
        chk("masked_load_sysregs", SysRegs, 48'h0000_0013_0011);

        // snap_seq wraps back to its start after 256 non-empty loads
        for (int i = 0; i < 256; i++) cycle(1, 8'h0C, 8'h01, 0);
        chk("seq_wrap", snap_seq, 8'h01);
        check_model("wrap");

        // Overrun saturation
        for (int i = 0; i < 300; i++) cycle(1, 8'h0E, 8'h00, 0);
        cycle(0, 8'h0D, 8'h00, 0);
        chk("ovr_saturate", DataOut, 8'hFF);
        check_model("sat");
        cycle(1, 8'h0D, 8'h00, 1);
        cycle(0, 8'h0D, 8'h00, 0);
        chk("ovr_clear", DataOut, 8'h00);
        check_model("clr");

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 16));
            a[7:5] = 3'($urandom_range(0, 7));
            MapVal    = 2'($urandom_range(0, 3));
            MotCtl    = 8'($urandom_range(0, 255));
            BotConfig = 8'($urandom_range(0, 255));
            cycle(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0));
            check_model("rnd");
        end

        // Asynchronous reset in the middle of a pending write
        cycle(1, 8'h08, 8'h77, 0);
        cycle(1, 8'h0E, 8'h00, 0);
        Wr_Strobe = 1'b1; AddrIn = 8'h01; DataIn = 8'h99; upd_ack = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_dout", DataOut, 8'h00);
        chk("arst_sys", SysRegs, 48'h0);
        chk("arst_mapx", MapX, 8'h00);
        chk("arst_mapy", MapY, 8'h00);
        chk("arst_upd", upd_sysregs, 1'b0);
        chk("arst_seq", snap_seq, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1, 8'h08, 8'h44, 0);
        check_model("post_rst_wr");
        cycle(0, 8'h10, 8'h00, 0);
        chk("post_rst_seq_read", DataOut, 8'h00);
        cycle(0, 8'h08, 8'h00, 0);
        chk("post_rst_mapx_read", DataOut, 8'h44);
        cycle(0, 8'h01, 8'h00, 0);
        chk("post_rst_hold0", DataOut, 8'h00);
        check_model("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
